zl_ts_sync_ctrl: RTL and testbench

ZL_TS_SYNC_CTRL -- requirements
Module: zl_ts_sync_ctrl

---
 rtl/zl_ts_sync_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_zl_ts_sync_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/zl_ts_sync_ctrl.sv
// Transport-stream sync acquisition: hunts for 0x47/0xB8 sync bytes, verifies packet
// alignment, then forwards locked packets through a one-deep output register with arm tags.
module zl_ts_sync_ctrl #(
  parameter int unsigned Packet_len   = 204,
  parameter int unsigned Lock_count   = 3,
  parameter int unsigned Unlock_count = 3,
  parameter int unsigned N_arms       = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_in_req,
  output logic        data_in_ack,
  input  logic [7:0]  data_in,
  output logic        data_out_req,
  input  logic        data_out_ack,
  output logic [7:0]  data_out,
  output logic        data_out_sop,
  output logic [3:0]  data_out_arm,
  output logic        locked,
  output logic [15:0] sync_err_count
);

  localparam int unsigned PosW   = (Packet_len > 1) ? $clog2(Packet_len) : 1;
  localparam int unsigned CntMax = (Lock_count > Unlock_count) ? Lock_count : Unlock_count;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [PosW-1:0] PosLast = PosW'(Packet_len - 1);
  localparam logic [3:0]      ArmLast = 4'(N_arms - 1);
  localparam logic [CntW-1:0] LockN   = CntW'(Lock_count);
  localparam logic [CntW-1:0] UnlockN = CntW'(Unlock_count);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCK
  } state_e;

  state_e          state_q, state_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [3:0]      arm_q, arm_d;
  logic [CntW-1:0] vcnt_q, vcnt_d;
  logic [CntW-1:0] mcnt_q, mcnt_d;
  logic [15:0]     err_q, err_d;
  logic [7:0]      dout_q, dout_d;
  logic            req_q, req_d;
  logic            sop_q, sop_d;
  logic [3:0]      oarm_q, oarm_d;

  logic            in_xfer;
  logic            is_sync;
  logic            at_sop;
  logic            fwd;
  logic [PosW-1:0] pos_inc;
  logic [3:0]      arm_inc;
  logic [CntW-1:0] vcnt_inc;
  logic [CntW-1:0] mcnt_inc;

  // In LOCK a byte may only be taken when the output register is free or draining.
  assign data_in_ack = data_in_req && (state_q != LOCK || !req_q || data_out_ack);
  assign in_xfer     = data_in_req && data_in_ack;
  assign is_sync     = (data_in == 8'h47) || (data_in == 8'hB8);
  assign at_sop      = (pos_q == '0);

  // arm_q runs alongside pos_q as pos mod N_arms; both wrap together at packet end.
  assign pos_inc  = (pos_q == PosLast) ? '0 : pos_q + PosW'(1);
  assign arm_inc  = (pos_q == PosLast || arm_q == ArmLast) ? '0 : arm_q + 4'd1;
  assign vcnt_inc = vcnt_q + CntW'(1);
  assign mcnt_inc = mcnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    arm_d   = arm_q;
    vcnt_d  = vcnt_q;
    mcnt_d  = mcnt_q;
    err_d   = err_q;
    fwd     = 1'b0;
    if (in_xfer) begin
      case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d = VERIFY;
            vcnt_d  = CntW'(1);
            pos_d   = pos_inc;
            arm_d   = arm_inc;
          end
        end
        VERIFY: begin
          pos_d = pos_inc;
          arm_d = arm_inc;
          if (at_sop) begin
            if (is_sync) begin
              vcnt_d = vcnt_inc;
              if (vcnt_inc == LockN) begin
                state_d = LOCK;
                vcnt_d  = '0;
                fwd     = 1'b1;
              end
            end else begin
              state_d = HUNT;
              vcnt_d  = '0;
              pos_d   = '0;
              arm_d   = '0;
            end
          end
        end
        LOCK: begin
          pos_d = pos_inc;
          arm_d = arm_inc;
          fwd   = 1'b1;
          if (at_sop) begin
            if (is_sync) begin
              mcnt_d = '0;
            end else begin
              if (err_q != '1) err_d = err_q + 16'd1;
              mcnt_d = mcnt_inc;
              if (mcnt_inc == UnlockN) begin
                state_d = HUNT;
                mcnt_d  = '0;
                pos_d   = '0;
                arm_d   = '0;
                fwd     = 1'b0;
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
          arm_d   = '0;
          vcnt_d  = '0;
          mcnt_d  = '0;
        end
      endcase
    end
  end

  // Output stage: a new forward overwrites only a byte that is leaving this same cycle.
  always_comb begin
    dout_d = dout_q;
    req_d  = req_q;
    sop_d  = sop_q;
    oarm_d = oarm_q;
    if (fwd) begin
      dout_d = data_in;
      req_d  = 1'b1;
      sop_d  = at_sop;
      oarm_d = arm_q;
    end else if (req_q && data_out_ack) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      pos_q   <= '0;
      arm_q   <= '0;
      vcnt_q  <= '0;
      mcnt_q  <= '0;
      err_q   <= '0;
      dout_q  <= '0;
      req_q   <= 1'b0;
      sop_q   <= 1'b0;
      oarm_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      arm_q   <= arm_d;
      vcnt_q  <= vcnt_d;
      mcnt_q  <= mcnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      req_q   <= req_d;
      sop_q   <= sop_d;
      oarm_q  <= oarm_d;
    end
  end

  assign data_out_req   = req_q;
  assign data_out       = dout_q;
  assign data_out_sop   = sop_q;
  assign data_out_arm   = oarm_q;
  assign locked         = (state_q == LOCK);
  assign sync_err_count = err_q;

endmodule

// File: tb/tb_zl_ts_sync_ctrl.sv
// Directed bench for zl_ts_sync_ctrl: reset, lock acquisition, alternating syncs,
// sync-error handling, mid-stream reset and output backpressure.
`timescale 1ns/1ps
module tb_zl_ts_sync_ctrl;

  localparam int unsigned PLEN = 204;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in_req = 1'b0;
  logic        data_in_ack;
  logic [7:0]  data_in = '0;
  logic        data_out_req;
  logic        data_out_ack = 1'b1;
  logic [7:0]  data_out;
  logic        data_out_sop;
  logic [3:0]  data_out_arm;
  logic        locked;
  logic [15:0] sync_err_count;

  always #5 clk = ~clk;

  zl_ts_sync_ctrl #(
    .Packet_len  (PLEN),
    .Lock_count  (3),
    .Unlock_count(3),
    .N_arms      (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in_req   (data_in_req),
    .data_in_ack   (data_in_ack),
    .data_in       (data_in),
    .data_out_req  (data_out_req),
    .data_out_ack  (data_out_ack),
    .data_out      (data_out),
    .data_out_sop  (data_out_sop),
    .data_out_arm  (data_out_arm),
    .locked        (locked),
    .sync_err_count(sync_err_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [12:0] rx_q[$];
  logic [12:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+2, so the negedge sees exactly what the next posedge will.
  always @(negedge clk) begin
    if (rst_n && data_out_req && data_out_ack)
      rx_q.push_back({data_out, data_out_sop, data_out_arm});
    if (data_in_ack && !data_in_req)
      check_eq("ack_without_req", data_in_ack, data_in_req);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] pbyte(input int unsigned p, input int unsigned i,
                                       input logic [7:0] sync);
    logic [7:0] v;
    v = 8'((i * 5 + p) & 255);
    return (i == 0) ? sync : v;
  endfunction

  task automatic expect_pkt(input int unsigned p, input logic [7:0] sync);
    for (int unsigned i = 0; i < PLEN; i++)
      exp_q.push_back({pbyte(p, i, sync), (i == 0), 4'(i % 12)});
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    data_in_req = 1'b1;
    data_in     = b;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = data_in_ack;
      @(posedge clk);
      #2;
    end
    if (!ok) check_eq("in_ack_timeout", ok, 1);
  endtask

  task automatic send_rest(input int unsigned p, input logic [7:0] sync, input int unsigned first);
    for (int unsigned i = first; i < PLEN; i++) send(pbyte(p, i, sync));
  endtask

  task automatic idle(input int unsigned n);
    data_in_req = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic compare_rx(input string tag);
    int unsigned n;
    check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++)
      check_eq($sformatf("%s[%0d]", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  logic [7:0]  esync [6] = '{8'h46, 8'hB9, 8'h47, 8'h00, 8'hFF, 8'h48};
  logic [15:0] eerr  [6] = '{16'd1, 16'd2, 16'd2, 16'd3, 16'd4, 16'd5};
  logic        elock [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    // Reset with an active upstream
    data_in_req = 1'b1;
    data_in     = 8'h47;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_req",    data_out_req,   0);
    check_eq("rst_data",   data_out,       0);
    check_eq("rst_sop",    data_out_sop,   0);
    check_eq("rst_arm",    data_out_arm,   0);
    check_eq("rst_locked", locked,         0);
    check_eq("rst_errcnt", sync_err_count, 0);
    data_in_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Clean 0x47 stream, 5 packets
    for (int unsigned p = 0; p < 5; p++) begin
      for (int unsigned i = 0; i < PLEN; i++) begin
        send(pbyte(p, i, 8'h47));
        if (p == 1 && i == PLEN - 1) check_eq("clean_not_yet_locked", locked, 0);
        if (p == 2 && i == 0) begin
          check_eq("clean_lock",     locked,       1);
          check_eq("clean_first_req", data_out_req, 1);
          check_eq("clean_first_byte", data_out,   8'h47);
          check_eq("clean_first_sop", data_out_sop, 1);
          check_eq("clean_first_arm", data_out_arm, 0);
        end
      end
    end
    idle(3);
    for (int unsigned p = 2; p < 5; p++) expect_pkt(p, 8'h47);
    compare_rx("clean");

    // Reset in the middle of a locked packet
    for (int unsigned i = 0; i < 100; i++) send(pbyte(5, i, 8'h47));
    rst_n = 1'b0;
    #1;
    check_eq("midrst_req",    data_out_req,   0);
    check_eq("midrst_data",   data_out,       0);
    check_eq("midrst_sop",    data_out_sop,   0);
    check_eq("midrst_arm",    data_out_arm,   0);
    check_eq("midrst_locked", locked,         0);
    check_eq("midrst_errcnt", sync_err_count, 0);
    @(posedge clk);
    #2;
    check_eq("midrst_req_next", data_out_req, 0);
    rst_n = 1'b1;
    rx_q.delete();
    exp_q.delete();
    send(8'h00);
    check_eq("post_rst_hunt", locked, 0);

    // Alternating B8/47 syncs
    for (int unsigned p = 10; p < 14; p++)
      send_rest(p, (p % 2 == 0) ? 8'hB8 : 8'h47, 0);
    check_eq("alt_locked", locked, 1);
    idle(3);
    expect_pkt(12, 8'hB8);
    expect_pkt(13, 8'h47);
    compare_rx("alt");

    // Bad syncs while locked: 2 bad, 1 good, then 3 bad
    for (int unsigned k = 0; k < 6; k++) begin
      send(pbyte(20 + k, 0, esync[k]));
      check_eq($sformatf("err_locked_%0d", k), locked, elock[k]);
      check_eq($sformatf("err_count_%0d", k), sync_err_count, eerr[k]);
      if (k < 5) begin
        send_rest(20 + k, esync[k], 1);
        expect_pkt(20 + k, esync[k]);
      end
    end
    check_eq("err_unlock_no_fwd", data_out_req, 0);
    idle(3);
    compare_rx("err");

    // Backpressure while locked
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_rest(30, 8'h47, 0);
    send_rest(31, 8'h47, 0);
    data_out_ack = 1'b0;
    send(pbyte(32, 0, 8'h47));
    check_eq("bp_locked", locked, 1);
    data_in_req = 1'b1;
    data_in     = pbyte(32, 1, 8'h47);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq($sformatf("bp_in_ack_%0d", c), data_in_ack, 0);
      check_eq($sformatf("bp_req_%0d", c), data_out_req, 1);
      check_eq($sformatf("bp_data_%0d", c), data_out, 8'h47);
      check_eq($sformatf("bp_sop_%0d", c), data_out_sop, 1);
    end
    @(posedge clk);
    #2;
    data_out_ack = 1'b1;
    send_rest(32, 8'h47, 1);
    idle(3);
    expect_pkt(32, 8'h47);
    compare_rx("bp");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
